// File: rtl/pe_rst_pkg.sv
// Shared types and defaults for the per-PE reset sequencer.
package pe_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } rst_state_e;

    localparam int RST_ASSERT_CYCLES = 16;
    localparam int RST_GAP_CYCLES    = 4;

    // Counter must hold the larger of the two hold times without wrapping.
    function automatic int cnt_w(input int a, input int g);
        int m;
        m = (a > g) ? a : g;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_next_sel.sv
// Finds the lowest set bit at or above a start index; flags when it is the last set bit.
module rst_next_sel #(
    parameter int W  = 5,
    parameter int IW = 3
) (
    input  logic [W-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          hit,
    output logic [IW-1:0] sel,
    output logic          last
);

    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        last = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (vec[i] && (IW'(i) >= start)) begin
                if (!hit) begin
                    hit = 1'b1;
                    sel = IW'(i);
                end else begin
                    last = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pe_rst_seq.sv
// Stretches per-PE soft-reset pulses into ordered reset lines: SRAM first, then modules ascending.
module pe_rst_seq
    import pe_rst_pkg::*;
#(
    parameter int N_MOD         = 4,
    parameter int ASSERT_CYCLES = RST_ASSERT_CYCLES,
    parameter int GAP_CYCLES    = RST_GAP_CYCLES
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic [N_MOD-1:0] mod_soft_rstn_i,
    input  logic             sram_soft_rstn_i,
    output logic [N_MOD-1:0] mod_rstn_o,
    output logic             sram_rstn_o,
    output logic             busy_o
);

    localparam int NL = N_MOD + 1;
    localparam int IW = $clog2(NL);
    localparam int CW = cnt_w(ASSERT_CYCLES, GAP_CYCLES);

    // Line vectors are {mod[N_MOD-1:0], sram}: bit 0 is the SRAM, so it releases first.
    rst_state_e     state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [IW-1:0]  idx, idx_nx;
    logic [NL-1:0]  active, active_nx;
    logic [NL-1:0]  pending, pending_nx;
    logic [NL-1:0]  rstn_q, rstn_nx;
    logic [NL-1:0]  req_vec, req_all;
    logic [IW-1:0]  sel_start, sel;
    logic           hit, last, rel_due;

    assign req_vec   = {~mod_soft_rstn_i | {N_MOD{~sram_soft_rstn_i}}, ~sram_soft_rstn_i};
    assign req_all   = pending | req_vec;
    assign sel_start = (state == RELEASE) ? idx : '0;
    assign rel_due   = ((state == ASSERT)  && (cnt == CW'(ASSERT_CYCLES - 1))) ||
                       ((state == RELEASE) && (cnt == CW'(GAP_CYCLES - 1)));

    rst_next_sel #(
        .W  (NL),
        .IW (IW)
    ) u_next_sel (
        .vec   (active),
        .start (sel_start),
        .hit   (hit),
        .sel   (sel),
        .last  (last)
    );

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        active_nx  = active;
        pending_nx = pending;
        rstn_nx    = rstn_q;
        case (state)
            IDLE: begin
                if (|req_all) begin
                    active_nx  = req_all;
                    pending_nx = '0;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    rstn_nx    = rstn_q & ~req_all;
                    state_nx   = ASSERT;
                end
            end
            ASSERT, RELEASE: begin
                // New requests never touch the running sequence; they wait for the next one.
                pending_nx = req_all;
                if (rel_due) begin
                    if (hit) begin
                        rstn_nx[sel] = 1'b1;
                    end
                    cnt_nx   = '0;
                    idx_nx   = sel + 1'b1;
                    state_nx = last ? IDLE : RELEASE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            active  <= '1;
            pending <= '0;
            rstn_q  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            active  <= active_nx;
            pending <= pending_nx;
            rstn_q  <= rstn_nx;
        end
    end

    assign sram_rstn_o = rstn_q[0];
    assign mod_rstn_o  = rstn_q[NL-1:1];
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_pe_rst_seq.sv
// Directed and randomized checks of pe_rst_seq against a release-schedule reference model.
module tb_pe_rst_seq;

    localparam int N_MOD = 4;
    localparam int AC    = 16;
    localparam int GC    = 4;
    localparam int NL    = N_MOD + 1;

    logic             sys_clk = 1'b0;
    logic             sys_rstn = 1'b0;
    logic [N_MOD-1:0] mod_soft_rstn_i = '1;
    logic             sram_soft_rstn_i = 1'b1;
    logic [N_MOD-1:0] mod_rstn_o;
    logic             sram_rstn_o;
    logic             busy_o;

    always #5 sys_clk = ~sys_clk;

    pe_rst_seq #(
        .N_MOD         (N_MOD),
        .ASSERT_CYCLES (AC),
        .GAP_CYCLES    (GC)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rstn         (sys_rstn),
        .mod_soft_rstn_i  (mod_soft_rstn_i),
        .sram_soft_rstn_i (sram_soft_rstn_i),
        .mod_rstn_o       (mod_rstn_o),
        .sram_rstn_o      (sram_rstn_o),
        .busy_o           (busy_o)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int now       = 0;

    // Reference model: each sequence is a list of absolute release times.
    logic [NL-1:0] m_out  = '0;
    logic [NL-1:0] m_pend = '0;
    logic          m_busy = 1'b1;
    int            rel_t[NL];
    int            end_t  = 0;

    task automatic start_seq(input logic [NL-1:0] v);
        int k;
        k = 0;
        m_busy = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (v[i]) begin
                rel_t[i] = now + AC + k * GC;
                k++;
            end else begin
                rel_t[i] = -1;
            end
        end
        end_t = now + AC + (k - 1) * GC;
    endtask

    task automatic model_step(input logic rstn, input logic [N_MOD-1:0] mn, input logic sn);
        logic [NL-1:0] req;
        logic [NL-1:0] v;
        req = {~mn | {N_MOD{~sn}}, ~sn};
        if (!rstn) begin
            m_out  = '0;
            m_pend = '0;
            start_seq('1);
        end else if (m_busy) begin
            m_pend = m_pend | req;
            for (int i = 0; i < NL; i++)
                if (rel_t[i] == now) m_out[i] = 1'b1;
            if (now == end_t) m_busy = 1'b0;
        end else begin
            v = m_pend | req;
            if (v != '0) begin
                m_out  = m_out & ~v;
                m_pend = '0;
                start_seq(v);
            end
        end
    endtask

    task automatic tick(input logic rstn, input logic [N_MOD-1:0] mn, input logic sn);
        @(negedge sys_clk);
        sys_rstn         = rstn;
        mod_soft_rstn_i  = mn;
        sram_soft_rstn_i = sn;
        @(posedge sys_clk);
        now++;
        model_step(rstn, mn, sn);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (m_busy || m_pend != '0); i++) tick(1'b1, '1, 1'b1);
        total_cnt++;
        if (m_busy || m_pend != '0 || busy_o !== 1'b0)
            $display("FAIL wait_idle busy=%b required 0", busy_o);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        for (int r = 0; r < 5; r++) begin
            tick(1'b0, '1, 1'b1);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== 6'b000001)
                $display("FAIL reset_hold got %b required 000001", {mod_rstn_o, sram_rstn_o, busy_o});
            else
                pass_cnt++;
        end
        for (int r = 1; r <= 36; r++) begin
            tick(1'b1, '1, 1'b1);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== {m_out, m_busy})
                $display("FAIL por_model r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, {m_out, m_busy});
            else
                pass_cnt++;
            if (r == 15 || r == 16 || r == 20 || r == 24 || r == 28 || r == 31 || r == 32) begin
                logic [5:0] exp;
                case (r)
                    15:      exp = 6'b000001;
                    16:      exp = 6'b000011;
                    20:      exp = 6'b000111;
                    24:      exp = 6'b001111;
                    28:      exp = 6'b011111;
                    31:      exp = 6'b011111;
                    default: exp = 6'b111110;
                endcase
                total_cnt++;
                if ({mod_rstn_o, sram_rstn_o, busy_o} !== exp)
                    $display("FAIL por_sched r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, exp);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_single_mod();
        int low_cnt, busy_cnt;
        logic other_low;
        tick(1'b1, 4'b1011, 1'b1);
        total_cnt++;
        if ({mod_rstn_o, sram_rstn_o, busy_o} !== 6'b101111)
            $display("FAIL single_edge got %b required 101111", {mod_rstn_o, sram_rstn_o, busy_o});
        else
            pass_cnt++;
        low_cnt = 1; busy_cnt = 1; other_low = 1'b0;
        for (int r = 1; r <= 20; r++) begin
            tick(1'b1, '1, 1'b1);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== {m_out, m_busy})
                $display("FAIL single_model r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, {m_out, m_busy});
            else
                pass_cnt++;
            if (!mod_rstn_o[2]) low_cnt++;
            if (busy_o) busy_cnt++;
            if ((mod_rstn_o | 4'b0100) !== 4'b1111 || sram_rstn_o !== 1'b1) other_low = 1'b1;
        end
        total_cnt++;
        if (low_cnt != 16 || busy_cnt != 16 || other_low)
            $display("FAIL single_len low=%0d busy=%0d other=%b required 16 16 0", low_cnt, busy_cnt, other_low);
        else
            pass_cnt++;
    endtask

    task automatic test_sram();
        tick(1'b1, '1, 1'b0);
        total_cnt++;
        if ({mod_rstn_o, sram_rstn_o, busy_o} !== 6'b000001)
            $display("FAIL sram_edge got %b required 000001", {mod_rstn_o, sram_rstn_o, busy_o});
        else
            pass_cnt++;
        for (int r = 1; r <= 34; r++) begin
            tick(1'b1, '1, 1'b1);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== {m_out, m_busy})
                $display("FAIL sram_model r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, {m_out, m_busy});
            else
                pass_cnt++;
            if (r == 16 || r == 24 || r == 32) begin
                logic [5:0] exp;
                exp = (r == 16) ? 6'b000011 : (r == 24) ? 6'b001111 : 6'b111110;
                total_cnt++;
                if ({mod_rstn_o, sram_rstn_o, busy_o} !== exp)
                    $display("FAIL sram_sched r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, exp);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int low1, falls;
        logic prev1;
        tick(1'b1, 4'b1110, 1'b1);
        low1 = 0; falls = 0; prev1 = mod_rstn_o[1];
        for (int r = 1; r <= 60; r++) begin
            tick(1'b1, (r == 5 || r == 9) ? 4'b1101 : 4'b1111, 1'b1);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== {m_out, m_busy})
                $display("FAIL b2b_model r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, {m_out, m_busy});
            else
                pass_cnt++;
            if (!mod_rstn_o[1]) low1++;
            if (prev1 && !mod_rstn_o[1]) falls++;
            prev1 = mod_rstn_o[1];
            if (r == 16 || r == 17) begin
                logic [5:0] exp;
                exp = (r == 16) ? 6'b111110 : 6'b110111;
                total_cnt++;
                if ({mod_rstn_o, sram_rstn_o, busy_o} !== exp)
                    $display("FAIL b2b_gap r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, exp);
                else
                    pass_cnt++;
            end
        end
        total_cnt++;
        if (low1 != 16 || falls != 1 || busy_o !== 1'b0)
            $display("FAIL b2b_collapse low=%0d falls=%0d busy=%b required 16 1 0", low1, falls, busy_o);
        else
            pass_cnt++;
    endtask

    task automatic test_mid_reset();
        tick(1'b1, '1, 1'b0);
        for (int r = 1; r <= 22; r++)
            tick(r != 22, (r == 10) ? 4'b1011 : 4'b1111, 1'b1);
        total_cnt++;
        if ({mod_rstn_o, sram_rstn_o, busy_o} !== 6'b000001)
            $display("FAIL midrst_edge got %b required 000001", {mod_rstn_o, sram_rstn_o, busy_o});
        else
            pass_cnt++;
        for (int s = 1; s <= 36; s++) begin
            tick(1'b1, '1, 1'b1);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== {m_out, m_busy})
                $display("FAIL midrst_model s=%0d got %b required %b", s, {mod_rstn_o, sram_rstn_o, busy_o}, {m_out, m_busy});
            else
                pass_cnt++;
            if (s == 15 || s == 16 || s == 20 || s == 32 || s == 36) begin
                logic [5:0] exp;
                case (s)
                    15:      exp = 6'b000001;
                    16:      exp = 6'b000011;
                    20:      exp = 6'b000111;
                    default: exp = 6'b111110;
                endcase
                total_cnt++;
                if ({mod_rstn_o, sram_rstn_o, busy_o} !== exp)
                    $display("FAIL midrst_sched s=%0d got %b required %b", s, {mod_rstn_o, sram_rstn_o, busy_o}, exp);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_dual();
        logic never02;
        tick(1'b1, 4'b0101, 1'b1);
        never02 = (mod_rstn_o[0] === 1'b1) && (mod_rstn_o[2] === 1'b1);
        for (int r = 1; r <= 24; r++) begin
            tick(1'b1, '1, 1'b1);
            if (mod_rstn_o[0] !== 1'b1 || mod_rstn_o[2] !== 1'b1) never02 = 1'b0;
            if (r == 15 || r == 16 || r == 20) begin
                logic [5:0] exp;
                exp = (r == 15) ? 6'b010111 : (r == 16) ? 6'b011111 : 6'b111110;
                total_cnt++;
                if ({mod_rstn_o, sram_rstn_o, busy_o} !== exp)
                    $display("FAIL dual_sched r=%0d got %b required %b", r, {mod_rstn_o, sram_rstn_o, busy_o}, exp);
                else
                    pass_cnt++;
            end
        end
        total_cnt++;
        if (!never02)
            $display("FAIL dual_untouched got low on mod0/mod2 required never");
        else
            pass_cnt++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            logic [N_MOD-1:0] mn;
            logic sn, rn;
            rn = ($urandom_range(0, 399) != 0);
            sn = ($urandom_range(0, 149) != 0);
            for (int b = 0; b < N_MOD; b++) mn[b] = ($urandom_range(0, 39) != 0);
            tick(rn, mn, sn);
            total_cnt++;
            if ({mod_rstn_o, sram_rstn_o, busy_o} !== {m_out, m_busy})
                $display("FAIL random c=%0d got %b required %b", c, {mod_rstn_o, sram_rstn_o, busy_o}, {m_out, m_busy});
            else
                pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        wait_idle();
        test_single_mod();
        wait_idle();
        test_sram();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_mid_reset();
        wait_idle();
        test_dual();
        wait_idle();
        test_random();
        wait_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
